// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg: shared FSM states, LUT index width and PC update modes for the program sequencer.
package prog_seq_pkg;
    localparam int LUT_IDX_W = 4;
    localparam int DEF_PC_W = 10;
    typedef enum logic [1:0] {IDLE, RUN, BR, DONE} state_t;
    typedef enum logic {PC_INC, PC_REL} pc_mode_t;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: next program counter, either PC+1 or PC+signed offset, modulo 2^PC_W.
module pc_next_calc
    import prog_seq_pkg::*;
#(
    parameter int PC_W = DEF_PC_W
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] offset,
    input  pc_mode_t        mode,
    output logic [PC_W-1:0] next_pc
);
    // offset already spans PC_W bits, so a plain modular add is the sign-extended add
    assign next_pc = pc + ((mode == PC_REL) ? offset : PC_W'(1));
endmodule

// File: rtl/prog_seq_ctrl.sv
// prog_seq_ctrl: program counter sequencer with LUT-relative branches and a run-length watchdog.
// Optional BRANCH_STATS_EN adds a saturating BranchCnt of completed branches.
module prog_seq_ctrl
    import prog_seq_pkg::*;
#(
    parameter int PC_W     = DEF_PC_W,
    parameter int START_PC = 0,
    parameter int MAX_CYC  = 4095
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Stall,
    input  logic                 Halt,
    input  logic                 BranchEn,
    input  logic [LUT_IDX_W-1:0] TargetIdx,
    input  logic [PC_W-1:0]      LutOut,
    output logic [LUT_IDX_W-1:0] LutIdx,
    output logic [PC_W-1:0]      PC,
    output logic                 Fetch,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Timeout
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]          BranchCnt
`endif
);
    localparam int CW = $clog2(MAX_CYC + 1);

    state_t         state;
    logic [CW-1:0]  cyc;
    logic [PC_W-1:0] pc_nxt;
    logic           active;
    logic           wd_last;

    assign active  = (state == RUN || state == BR) && !Stall;
    assign wd_last = active && (cyc == CW'(MAX_CYC - 1));
    assign Fetch   = (state == RUN) && !Stall;
    assign Busy    = (state == RUN) || (state == BR);
    assign Done    = (state == DONE);

    pc_next_calc #(.PC_W(PC_W)) u_next (
        .pc      (PC),
        .offset  (LutOut),
        .mode    ((state == BR) ? PC_REL : PC_INC),
        .next_pc (pc_nxt)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            PC      <= PC_W'(START_PC);
            LutIdx  <= '0;
            cyc     <= '0;
            Timeout <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (Start) begin
                    state   <= RUN;
                    PC      <= PC_W'(START_PC);
                    cyc     <= '0;
                    Timeout <= 1'b0;
                end
                RUN: if (!Stall) begin
                    cyc <= cyc + 1'b1;
                    // the watchdog's final cycle still advances PC but ignores Halt and BranchEn
                    if (wd_last) begin
                        state   <= DONE;
                        Timeout <= 1'b1;
                        PC      <= pc_nxt;
                    end else if (Halt) begin
                        state <= DONE;
                    end else if (BranchEn) begin
                        LutIdx <= TargetIdx;
                        state  <= BR;
                    end else begin
                        PC <= pc_nxt;
                    end
                end
                BR: if (!Stall) begin
                    cyc     <= cyc + 1'b1;
                    PC      <= pc_nxt;
                    state   <= wd_last ? DONE : RUN;
                    Timeout <= wd_last;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            BranchCnt <= '0;
        else if ((state == IDLE || state == DONE) && Start)
            BranchCnt <= '0;
        else if (state == BR && active && !wd_last && BranchCnt != 16'hFFFF)
            BranchCnt <= BranchCnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_prog_seq_ctrl.sv
// tb_prog_seq_ctrl: two sequencers (default watchdog and MAX_CYC=8) on shared stimulus against an arithmetic model.
module tb_prog_seq_ctrl;
    localparam int M = 1024;
    localparam int S_IDLE = 0, S_RUN = 1, S_BR = 2, S_DONE = 3;

    logic clk = 0, rst_n = 0, start = 0, stall = 0, halt = 0, br_en = 0;
    logic [3:0] tidx = '0;
    logic [9:0] lut_out = '0;
    logic [3:0] lut_o [2];
    logic [9:0] pc_o [2];
    logic fetch_o [2], busy_o [2], done_o [2], to_o [2];
`ifdef BRANCH_STATS_EN
    logic [15:0] bc_o [2];
`endif
    int total = 0, bad = 0;
    int m_st [2], m_pc [2], m_cyc [2], m_lut [2], m_to [2], m_bc [2];

    always #5 clk = ~clk;

    prog_seq_ctrl u0 (
        .Clk(clk), .Reset(rst_n), .Start(start), .Stall(stall), .Halt(halt),
        .BranchEn(br_en), .TargetIdx(tidx), .LutOut(lut_out), .LutIdx(lut_o[0]),
        .PC(pc_o[0]), .Fetch(fetch_o[0]), .Busy(busy_o[0]), .Done(done_o[0]), .Timeout(to_o[0])
`ifdef BRANCH_STATS_EN
        , .BranchCnt(bc_o[0])
`endif
    );

    prog_seq_ctrl #(.MAX_CYC(8)) u1 (
        .Clk(clk), .Reset(rst_n), .Start(start), .Stall(stall), .Halt(halt),
        .BranchEn(br_en), .TargetIdx(tidx), .LutOut(lut_out), .LutIdx(lut_o[1]),
        .PC(pc_o[1]), .Fetch(fetch_o[1]), .Busy(busy_o[1]), .Done(done_o[1]), .Timeout(to_o[1])
`ifdef BRANCH_STATS_EN
        , .BranchCnt(bc_o[1])
`endif
    );

    function automatic int maxc(int k);
        return (k == 0) ? 4095 : 8;
    endfunction

    function automatic int wrap(int v);
        return ((v % M) + M) % M;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // model: program state per instance, updated from the rules on each edge
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_st[k] <= S_IDLE; m_pc[k] <= 0; m_cyc[k] <= 0; m_lut[k] <= 0; m_to[k] <= 0; m_bc[k] <= 0;
            end else if (m_st[k] == S_IDLE || m_st[k] == S_DONE) begin
                if (start) begin
                    m_st[k] <= S_RUN; m_pc[k] <= 0; m_cyc[k] <= 0; m_to[k] <= 0; m_bc[k] <= 0;
                end
            end else if (!stall) begin
                m_cyc[k] <= m_cyc[k] + 1;
                if (m_cyc[k] + 1 >= maxc(k)) begin
                    m_st[k] <= S_DONE;
                    m_to[k] <= 1;
                    m_pc[k] <= wrap(m_pc[k] + ((m_st[k] == S_BR) ? int'($signed(lut_out)) : 1));
                end else if (m_st[k] == S_BR) begin
                    m_pc[k] <= wrap(m_pc[k] + int'($signed(lut_out)));
                    m_st[k] <= S_RUN;
                    m_bc[k] <= (m_bc[k] < 65535) ? m_bc[k] + 1 : 65535;
                end else if (halt) begin
                    m_st[k] <= S_DONE;
                end else if (br_en) begin
                    m_lut[k] <= int'(tidx);
                    m_st[k] <= S_BR;
                end else begin
                    m_pc[k] <= wrap(m_pc[k] + 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("pc%0d", k), int'(pc_o[k]), m_pc[k]);
            chk($sformatf("lutidx%0d", k), int'(lut_o[k]), m_lut[k]);
            chk($sformatf("fetch%0d", k), int'(fetch_o[k]), int'(m_st[k] == S_RUN && !stall));
            chk($sformatf("busy%0d", k), int'(busy_o[k]), int'(m_st[k] == S_RUN || m_st[k] == S_BR));
            chk($sformatf("done%0d", k), int'(done_o[k]), int'(m_st[k] == S_DONE));
            chk($sformatf("timeout%0d", k), int'(to_o[k]), m_to[k]);
`ifdef BRANCH_STATS_EN
            chk($sformatf("brcnt%0d", k), int'(bc_o[k]), m_bc[k]);
`endif
        end
    end

    initial begin
        step(2);
        chk("rst_pc", int'(pc_o[0]), 0);
        chk("rst_busy", int'(busy_o[0]), 0);
        chk("rst_lut", int'(lut_o[0]), 0);
        chk("rst_timeout", int'(to_o[0]), 0);
        rst_n = 1;
        step(1);
        start = 1; step(1); start = 0;
        chk("start_busy", int'(busy_o[0]), 1);
        chk("start_fetch", int'(fetch_o[0]), 1);
        chk("start_pc", int'(pc_o[0]), 0);
        for (int i = 1; i <= 3; i++) begin
            step(1);
            chk("inc_pc", int'(pc_o[0]), i);
        end
        halt = 1; br_en = 1; step(1); halt = 0; br_en = 0;
        chk("halt_done", int'(done_o[0]), 1);
        chk("halt_pc", int'(pc_o[0]), 3);
        step(2);
        chk("done_hold_pc", int'(pc_o[0]), 3);
        chk("done_hold", int'(done_o[0]), 1);
        start = 1; step(1); start = 0;
        chk("restart_pc", int'(pc_o[0]), 0);
        chk("restart_done", int'(done_o[0]), 0);
        step(5);
        chk("pc5", int'(pc_o[0]), 5);
        br_en = 1; tidx = 0; lut_out = 10'h26E; step(1); br_en = 0; tidx = 5;
        chk("br_lutidx", int'(lut_o[0]), 0);
        chk("br_fetch", int'(fetch_o[0]), 0);
        chk("br_busy", int'(busy_o[0]), 1);
        chk("br_pc_hold", int'(pc_o[0]), 5);
        step(1);
        chk("br_target", int'(pc_o[0]), 627);
        br_en = 1; tidx = 9; lut_out = 10'd10; step(1); br_en = 0; stall = 1; tidx = 3; start = 1;
        for (int i = 0; i < 3; i++) begin
            step(1); start = 0;
            chk("stall_pc", int'(pc_o[0]), 627);
            chk("stall_lut", int'(lut_o[0]), 9);
            chk("stall_fetch", int'(fetch_o[0]), 0);
        end
        stall = 0; step(1);
        chk("stall_release_pc", int'(pc_o[0]), 637);
        br_en = 1; lut_out = 10'd386; step(1); br_en = 0; step(1);
        chk("pc_1023", int'(pc_o[0]), 1023);
        step(1);
        chk("wrap_up", int'(pc_o[0]), 0);
        br_en = 1; lut_out = 10'h3FF; step(1); br_en = 0; step(1);
        chk("wrap_down", int'(pc_o[0]), 1023);
        stall = 1; step(2);
        chk("run_stall_pc", int'(pc_o[0]), 1023);
        chk("run_stall_fetch", int'(fetch_o[0]), 0);
        stall = 0; step(1);
        chk("run_unstall_pc", int'(pc_o[0]), 0);
        br_en = 1; lut_out = 10'd7; step(1); br_en = 0;
        #2 rst_n = 0;
        #1;
        chk("rst_br_pc", int'(pc_o[0]), 0);
        chk("rst_br_busy", int'(busy_o[0]), 0);
        chk("rst_br_lut", int'(lut_o[0]), 0);
        chk("rst_br_fetch", int'(fetch_o[0]), 0);
        step(1); rst_n = 1; step(2);
        chk("post_rst_idle", int'(busy_o[0]), 0);
        chk("post_rst_pc", int'(pc_o[0]), 0);
        start = 1; step(1); start = 0;
        step(3);
        stall = 1; step(2);
        chk("wd_stall_pc", int'(pc_o[1]), 3);
        stall = 0; step(4);
        chk("wd_pc7", int'(pc_o[1]), 7);
        chk("wd_busy7", int'(busy_o[1]), 1);
        chk("wd_to7", int'(to_o[1]), 0);
        step(1);
        chk("wd_done", int'(done_o[1]), 1);
        chk("wd_timeout", int'(to_o[1]), 1);
        chk("wd_pc", int'(pc_o[1]), 8);
        chk("nowd_busy", int'(busy_o[0]), 1);
        start = 1; step(1); start = 0;
        chk("wd_restart_to", int'(to_o[1]), 0);
        chk("wd_restart_pc", int'(pc_o[1]), 0);
        chk("start_ignored_pc", int'(pc_o[0]), 9);
        step(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
